// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: valid/ready byte stream carrying received bytes to the system side
interface uart_rx_fifo_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  modport master(output m_data, output m_valid, input m_ready);
  modport slave(input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: syncs baud-domain rx bytes into clk, buffers them in a first-word-fall-through FIFO; UART_RX_FIFO_LEVEL_EN adds a level port
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  uart_rx_fifo_if.master m,
  output logic       full,
  output logic       overflow,
  input  logic       ovf_clr
`ifdef UART_RX_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0] level
`endif
);
  logic s1_q, s2_q, s3_q, live_q, armed_q, overflow_q;
  logic s1_d, s2_d, s3_d, live_d, armed_d, overflow_d;
  logic [ADDR_W:0] wr_q, rd_q, wr_d, rd_d;
  logic [7:0] mem_q [DEPTH];
  logic push, pop, do_push, empty;
  always_comb begin
    s1_d       = rx_valid;
    s2_d       = s1_q;
    s3_d       = s2_q;
    live_d     = 1'b1;
    armed_d    = armed_q | (live_q & ~s1_q);
    push       = s2_q & ~s3_q & armed_q;
    empty      = wr_q == rd_q;
    full       = (wr_q[ADDR_W-1:0] == rd_q[ADDR_W-1:0]) & (wr_q[ADDR_W] != rd_q[ADDR_W]);
    pop        = ~empty & m.m_ready;
    do_push    = push & (~full | pop);
    wr_d       = wr_q + (ADDR_W+1)'(do_push);
    rd_d       = rd_q + (ADDR_W+1)'(pop);
    overflow_d = (push & full & ~pop) ? 1'b1 : ovf_clr ? 1'b0 : overflow_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      live_q     <= 1'b0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      live_q     <= live_d;
      armed_q    <= armed_d;
      overflow_q <= overflow_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[ADDR_W-1:0]] <= rx_data;
  end
  assign m.m_valid = ~empty;
  assign m.m_data  = empty ? 8'h00 : mem_q[rd_q[ADDR_W-1:0]];
  assign overflow  = overflow_q;
`ifdef UART_RX_FIFO_LEVEL_EN
  logic [ADDR_W:0] level_q, level_d;
  always_comb level_d = level_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(pop);
  always_ff @(posedge clk) level_q <= rst ? '0 : level_d;
  assign level = level_q;
`endif
endmodule
